// File: rtl/ram_req_ctrl_pkg.sv
// ram_req_ctrl_pkg: shared FSM state encodings for the RAM request front-end.
package ram_req_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] WAIT  = 2'd2;
    localparam logic [STATE_W-1:0] RESP  = 2'd3;

endpackage : ram_req_ctrl_pkg

// File: rtl/ram_req_ctrl.sv
// ram_req_ctrl: valid/ready front-end for a single-port synchronous RAM.
// One request in flight; reads return on the rsp channel 3 cycles after the
// request handshake. Optional macro RAM_REQ_CTRL_WR_ACK_EN makes writes
// return a response (the written data) 2 cycles after their handshake.
module ram_req_ctrl
    import ram_req_ctrl_pkg::*;
#(
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned A_WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic               ram_w_r,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic [D_WIDTH-1:0] ram_data_in,
    input  logic [D_WIDTH-1:0] ram_data_out
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next_state;
    logic               r_w_r;
    logic [A_WIDTH-1:0] r_addr;
    logic [D_WIDTH-1:0] r_wdata;
    logic               r_rsp_valid;
    logic [D_WIDTH-1:0] r_rsp_data;

    // Ready is decoded from state and forced low while reset is held.
    assign req_ready   = (r_state == IDLE) && rst_n;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign ram_w_r     = r_w_r;
    assign ram_addr    = r_addr;
    assign ram_data_in = r_wdata;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (r_w_r) begin
`ifdef RAM_REQ_CTRL_WR_ACK_EN
                    w_next_state = RESP;
`else
                    w_next_state = IDLE;
`endif
                end else begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // RAM command and response registers; address/wdata hold their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_r       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_w_r   <= req_wr;
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                    end else begin
                        r_w_r   <= 1'b0;
                    end
                end
                ISSUE: begin
                    r_w_r <= 1'b0;
`ifdef RAM_REQ_CTRL_WR_ACK_EN
                    if (r_w_r) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_wdata;
                    end
`endif
                end
                WAIT: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= ram_data_out;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule : ram_req_ctrl
